// File: rtl/stopwatch_control_pkg.sv
// Shared definitions for the stopwatch control unit: state encodings,
// control word layout and constants, and the state transition rules.
package stopwatch_control_pkg;

    typedef enum logic [2:0] {
        StReset   = 3'd0,
        StStop    = 3'd1,
        StRun     = 3'd2,
        StInc     = 3'd3,
        StR2lr    = 3'd4,
        StLapRun  = 3'd5,
        StLapInc  = 3'd6,
        StLapStop = 3'd7
    } sw_state_e;

    // Tenth-second counter operation, cw[1:0]
    typedef enum logic [1:0] {
        TenthHold = 2'b00,
        TenthDown = 2'b01,
        TenthUp   = 2'b10,
        TenthLoad = 2'b11
    } tenth_op_e;

    // Control word layout, MSB first: cw[5] .. cw[0]
    typedef struct packed {
        logic      disp_lap;   // display mux: 1 = lap register
        logic      lap_load;   // lap register load
        logic      mod_clr;    // mod-10 counters synchronous reset
        logic      mod_en;     // mod-10 counters enable
        tenth_op_e tenth_op;   // tenth counter operation
    } cw_t;

    localparam cw_t CwReset   = '{disp_lap: 1'b0, lap_load: 1'b0, mod_clr: 1'b1,
                                  mod_en: 1'b0, tenth_op: TenthLoad};
    localparam cw_t CwStop    = '{disp_lap: 1'b0, lap_load: 1'b0, mod_clr: 1'b0,
                                  mod_en: 1'b0, tenth_op: TenthHold};
    localparam cw_t CwRun     = '{disp_lap: 1'b0, lap_load: 1'b0, mod_clr: 1'b0,
                                  mod_en: 1'b0, tenth_op: TenthUp};
    localparam cw_t CwInc     = '{disp_lap: 1'b0, lap_load: 1'b0, mod_clr: 1'b0,
                                  mod_en: 1'b1, tenth_op: TenthLoad};
    localparam cw_t CwR2lr    = '{disp_lap: 1'b1, lap_load: 1'b1, mod_clr: 1'b0,
                                  mod_en: 1'b0, tenth_op: TenthHold};
    localparam cw_t CwLapRun  = '{disp_lap: 1'b1, lap_load: 1'b0, mod_clr: 1'b0,
                                  mod_en: 1'b0, tenth_op: TenthUp};
    localparam cw_t CwLapInc  = '{disp_lap: 1'b1, lap_load: 1'b0, mod_clr: 1'b0,
                                  mod_en: 1'b1, tenth_op: TenthLoad};
    localparam cw_t CwLapStop = '{disp_lap: 1'b1, lap_load: 1'b0, mod_clr: 1'b0,
                                  mod_en: 1'b0, tenth_op: TenthHold};

    // Moore decode: control word for a given state
    function automatic cw_t cw_of(sw_state_e st);
        cw_t cw;
        cw = CwReset;
        case (st)
            StReset:   cw = CwReset;
            StStop:    cw = CwStop;
            StRun:     cw = CwRun;
            StInc:     cw = CwInc;
            StR2lr:    cw = CwR2lr;
            StLapRun:  cw = CwLapRun;
            StLapInc:  cw = CwLapInc;
            StLapStop: cw = CwLapStop;
            default:   cw = CwReset;
        endcase
        return cw;
    endfunction

    // Transition rules; priority clr > ss > lap > tenth, otherwise hold.
    // clr is only honoured in the stopped states.
    function automatic sw_state_e next_state(sw_state_e cur, logic clr_p, logic ss_p,
                                             logic lap_p, logic tenth);
        sw_state_e nxt;
        nxt = cur;
        case (cur)
            StReset: nxt = StStop;
            StStop: begin
                if (clr_p)     nxt = StReset;
                else if (ss_p) nxt = StRun;
            end
            StRun: begin
                if (ss_p)       nxt = StStop;
                else if (lap_p) nxt = StR2lr;
                else if (tenth) nxt = StInc;
            end
            StInc: begin
                if (ss_p)       nxt = StStop;
                else if (lap_p) nxt = StR2lr;
                else            nxt = StRun;
            end
            StR2lr: nxt = StLapRun;
            StLapRun: begin
                if (ss_p)       nxt = StLapStop;
                else if (lap_p) nxt = StRun;
                else if (tenth) nxt = StLapInc;
            end
            StLapInc: begin
                if (ss_p)       nxt = StLapStop;
                else if (lap_p) nxt = StRun;
                else            nxt = StLapRun;
            end
            StLapStop: begin
                if (clr_p)      nxt = StReset;
                else if (ss_p)  nxt = StLapRun;
                else if (lap_p) nxt = StStop;
            end
            default: nxt = StReset;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/btn_cond.sv
// Button conditioner: multi-stage synchroniser followed by a rising-edge
// one-cycle pulse generator. A button already held when reset releases is
// not reported until it has been seen low at least once.
module btn_cond #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic pulse
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] valid_q;  // marks synchroniser stages holding real samples
    logic                   prev_q;
    logic                   armed_q;  // set once a genuine low level has been observed

    // Synchroniser chain, edge-detect history and arming
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q  <= '0;
            valid_q <= '0;
            prev_q  <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            sync_q  <= (sync_q << 1) | SYNC_STAGES'(btn);
            valid_q <= (valid_q << 1) | SYNC_STAGES'(1'b1);
            prev_q  <= sync_q[SYNC_STAGES-1];
            armed_q <= armed_q | (valid_q[SYNC_STAGES-1] & ~sync_q[SYNC_STAGES-1]);
        end
    end

    assign pulse = sync_q[SYNC_STAGES-1] & ~prev_q & armed_q;

endmodule

// File: rtl/stopwatch_control.sv
// Moore control unit for the stopwatch: conditions the three buttons and
// sequences the datapath through its control word.
module stopwatch_control
    import stopwatch_control_pkg::*;
#(
    parameter int unsigned CW_WIDTH    = 6,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                btn_ss,
    input  logic                btn_lap,
    input  logic                btn_clr,
    input  logic                tenth,
    output logic [CW_WIDTH-1:0] cw,
    output logic [2:0]          state
);

    logic      ss_p;
    logic      lap_p;
    logic      clr_p;
    sw_state_e state_q;
    logic [CW_WIDTH-1:0] cw_q;

    btn_cond #(.SYNC_STAGES(SYNC_STAGES)) u_ss (
        .clk   (clk),
        .reset (reset),
        .btn   (btn_ss),
        .pulse (ss_p)
    );

    btn_cond #(.SYNC_STAGES(SYNC_STAGES)) u_lap (
        .clk   (clk),
        .reset (reset),
        .btn   (btn_lap),
        .pulse (lap_p)
    );

    btn_cond #(.SYNC_STAGES(SYNC_STAGES)) u_clr (
        .clk   (clk),
        .reset (reset),
        .btn   (btn_clr),
        .pulse (clr_p)
    );

    // State register with the control word registered alongside it
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StReset;
            cw_q    <= CW_WIDTH'(CwReset);
        end else begin
            state_q <= next_state(state_q, clr_p, ss_p, lap_p, tenth);
            cw_q    <= CW_WIDTH'(cw_of(next_state(state_q, clr_p, ss_p, lap_p, tenth)));
        end
    end

    assign cw    = cw_q;
    assign state = state_q;

endmodule

// File: tb/tb_stopwatch_control.sv
// Directed bench for stopwatch_control with a cycle-level reference model.
module tb_stopwatch_control;

    localparam int S    = 2;
    localparam int MAXC = 4096;
    localparam int BSS  = 0;
    localparam int BLAP = 1;
    localparam int BCLR = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn_ss = 1'b0;
    logic       btn_lap = 1'b0;
    logic       btn_clr = 1'b0;
    logic       tenth = 1'b0;
    logic [5:0] cw;
    logic [2:0] state;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    stopwatch_control #(.CW_WIDTH(6), .SYNC_STAGES(S)) dut (
        .clk     (clk),
        .reset   (reset),
        .btn_ss  (btn_ss),
        .btn_lap (btn_lap),
        .btn_clr (btn_clr),
        .tenth   (tenth),
        .cw      (cw),
        .state   (state)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [5:0] exp_cw [8] = '{6'b001011, 6'b000000, 6'b000010, 6'b000111,
                               6'b110000, 6'b100010, 6'b100111, 6'b100000};
    bit hist [3][MAXC];
    int k = -1;
    int last_reset = -1;
    int mstate = 0;
    bit mvalid = 0;

    // A press registers at edge kk when the raw samples S and S+1 edges
    // earlier show a low-to-high step and both were taken after reset.
    function automatic bit rise(input int b, input int kk);
        if (kk - S - 1 <= last_reset) return 1'b0;
        return hist[b][kk-S] && !hist[b][kk-S-1];
    endfunction

    function automatic int mnext(input int s, input bit c, input bit ss, input bit lp,
                                 input bit t);
        case (s)
            0: return 1;
            1: return c ? 0 : ss ? 2 : 1;
            2: return ss ? 1 : lp ? 4 : t ? 3 : 2;
            3: return ss ? 1 : lp ? 4 : 2;
            4: return 5;
            5: return ss ? 7 : lp ? 2 : t ? 6 : 5;
            6: return ss ? 7 : lp ? 2 : 5;
            7: return c ? 0 : ss ? 5 : lp ? 1 : 7;
            default: return 0;
        endcase
    endfunction

    always @(posedge clk) begin
        k++;
        if (k >= MAXC) begin
            $display("FAIL model history overflow at cycle %0d", k);
            $fatal(1, "history overflow");
        end
        hist[BSS][k]  = btn_ss && !reset;
        hist[BLAP][k] = btn_lap && !reset;
        hist[BCLR][k] = btn_clr && !reset;
        if (reset) begin
            last_reset = k;
            mstate = 0;
            mvalid = 1;
        end else begin
            mstate = mnext(mstate, rise(BCLR, k), rise(BSS, k), rise(BLAP, k), tenth);
        end
    end

    // Compare process
    always @(negedge clk) begin
        if (mvalid) begin
            chk("model_state", int'(state), mstate);
            chk("model_cw", int'(cw), int'(exp_cw[mstate]));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_btn(input int b, input logic v);
        case (b)
            BSS:     btn_ss = v;
            BLAP:    btn_lap = v;
            default: btn_clr = v;
        endcase
    endtask

    // One-cycle press; the effect is visible S cycles after return
    task automatic press(input int b);
        set_btn(b, 1'b1);
        step(1);
        set_btn(b, 1'b0);
    endtask

    // Press timed so that its pulse lands on the cycle spent in INC/LAPINC
    task automatic coincide(input int b);
        set_btn(b, 1'b1);
        step(1);
        tenth = 1'b1;
        step(1);
        tenth = 1'b0;
        set_btn(b, 1'b0);
        step(1);
    endtask

    initial begin
        // 1. reset then release
        step(1);
        chk("reset_state", int'(state), 0);
        chk("reset_cw", int'(cw), 6'b001011);
        step(1);
        chk("reset_state2", int'(state), 0);
        reset = 1'b0;
        step(1);
        chk("release_state", int'(state), 1);
        chk("release_cw", int'(cw), 6'b000000);
        step(4);

        // 2. run / tick
        press(BSS); step(S);
        chk("run_state", int'(state), 2);
        tenth = 1'b1; step(1); tenth = 1'b0;
        chk("inc_state", int'(state), 3);
        chk("inc_cw", int'(cw), 6'b000111);
        step(1);
        chk("inc_back_state", int'(state), 2);
        chk("inc_back_cw", int'(cw), 6'b000010);

        // 3. lap sequence
        press(BLAP); step(S);
        chk("r2lr_cw", int'(cw), 6'b110000);
        step(1);
        chk("laprun_cw", int'(cw), 6'b100010);
        tenth = 1'b1; step(1); tenth = 1'b0;
        chk("lapinc_cw", int'(cw), 6'b100111);
        step(1);
        chk("lapinc_back", int'(state), 5);
        press(BLAP); step(S);
        chk("lap_exit", int'(state), 2);

        // 4. stop and clear
        press(BLAP); step(S + 1);
        press(BSS); step(S);
        chk("lapstop_state", int'(state), 7);
        press(BCLR); step(S);
        chk("clr_state", int'(state), 0);
        step(1);
        chk("clr_then_stop", int'(state), 1);
        step(2);
        press(BSS); step(S);
        press(BCLR); step(S + 3);
        chk("clr_ignored_run", int'(state), 2);

        // button coinciding with a tick cycle
        coincide(BSS);
        chk("inc_ss_stop", int'(state), 1);
        press(BSS); step(S);
        coincide(BLAP);
        chk("inc_lap_r2lr", int'(state), 4);
        step(1);
        coincide(BLAP);
        chk("lapinc_lap_run", int'(state), 2);
        press(BLAP); step(S + 1);
        coincide(BSS);
        chk("lapinc_ss_lapstop", int'(state), 7);
        press(BSS); step(S);
        chk("lapstop_ss_laprun", int'(state), 5);
        press(BSS); step(S);
        press(BLAP); step(S);
        chk("lapstop_lap_stop", int'(state), 1);

        // STOP: lap and tenth ignored, clr wins over ss
        press(BLAP); step(S);
        tenth = 1'b1; step(2); tenth = 1'b0;
        chk("stop_hold", int'(state), 1);
        btn_clr = 1'b1; btn_ss = 1'b1; step(1); btn_clr = 1'b0; btn_ss = 1'b0;
        step(S);
        chk("clr_over_ss", int'(state), 0);
        step(1);

        // 5. simultaneous ss+lap with tenth in RUN
        press(BSS); step(S);
        btn_ss = 1'b1; btn_lap = 1'b1;
        step(S);
        tenth = 1'b1; btn_ss = 1'b0; btn_lap = 1'b0;
        step(1);
        tenth = 1'b0;
        chk("simul_stop", int'(state), 1);

        // lap beats tenth in RUN
        press(BSS); step(S);
        btn_lap = 1'b1; step(S); tenth = 1'b1; btn_lap = 1'b0; step(1); tenth = 1'b0;
        chk("lap_over_tenth", int'(state), 4);
        step(1);
        press(BLAP); step(S);

        // held ss for 50 cycles: exactly one transition (RUN -> STOP)
        btn_ss = 1'b1; step(50);
        chk("held_ss", int'(state), 1);
        btn_ss = 1'b0; step(3);

        // 6. reset in the middle of INC, with a button held through it
        press(BSS); step(S);
        tenth = 1'b1; step(1);
        chk("pre_reset_inc", int'(state), 3);
        tenth = 1'b0; reset = 1'b1; btn_ss = 1'b1;
        step(1);
        chk("mid_inc_reset_state", int'(state), 0);
        chk("mid_inc_reset_cw", int'(cw), 6'b001011);
        step(1);
        reset = 1'b0;
        step(10);
        chk("held_through_reset", int'(state), 1);
        btn_ss = 1'b0; step(2);
        press(BSS); step(S);
        chk("fresh_press_after_reset", int'(state), 2);

        // reset during R2LR
        press(BLAP); step(S);
        chk("pre_reset_r2lr", int'(state), 4);
        reset = 1'b1; step(1);
        chk("mid_r2lr_reset", int'(state), 0);
        reset = 1'b0; step(1);
        chk("after_r2lr_reset", int'(state), 1);
        step(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
